dht11_responder: RTL and testbench
==================================

Name: dht11_responder

Overview:
- Behavioural-synthesizable DHT11 sensor emulator: the responder end of the single-wire DHT11 protocol, opposite to our host start/receive logic.
- Watches the open-drain data line for the host start pulse, answers with the 80 us low / 80 us high acknowledge, then sends a 40-bit frame (humidity, temperature, checksum) and releases the line.
- Used in loopback benches and on FPGA as a stand-in sensor for validating the host-side receiver.

Parameters:
- TICKS_PER_US, 1, clk cycles per microsecond (1 MHz system clock default).
- START_MIN_US, 18000, minimum host low time accepted as a start request.
- RESP_DELAY_US, 30, wait after host release before the sensor pulls low.
- RESP_US, 80, duration of the acknowledge low and of the acknowledge high.
- BIT_LOW_US, 50, low preamble before every data bit and final end-of-frame low.
- BIT0_HIGH_US, 27, high time encoding '0'.
- BIT1_HIGH_US, 70, high time encoding '1'.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- dq_in  input  1  sampled level of the shared data line (pull-up high)
- dq_drive_low  output  1  1 = pull line low (tristate enable), 0 = release
- hum_int  input  8  humidity integer byte
- hum_dec  input  8  humidity decimal byte
- temp_int  input  8  temperature integer byte
- temp_dec  input  8  temperature decimal byte
- busy  output  1  high from start acceptance until frame end
- frame_done  output  1  one-cycle pulse when the line is released after the last bit

Behaviour:
- Reset (clk edge with rst=1): state IDLE, counters 0, dq_drive_low=0, busy=0, frame_done=0, sync flops=1. Reset mid-frame releases the line on that same edge.
- dq_in passes through a 2-flop synchronizer; all decisions use the synchronized level (2-cycle latency).
- Single counter wide enough for START_MIN_US*TICKS_PER_US; the width is derived from parameters with $clog2.
- All durations are N*TICKS_PER_US cycles exactly. A phase lasts N cycles, and the counter clears on every state change.
- IDLE: while the synced line is low, count. If the line goes high with count >= START_MIN cycles, go to WAIT_REL_DLY. If it goes high with a shorter count, clear the counter and stay in IDLE (glitch or short pulse ignored).
- Snapshot: on the IDLE->WAIT_REL_DLY transition, latch the 4 bytes into a 40-bit shift register {hum_int,hum_dec,temp_int,temp_dec,checksum}. The checksum is the sum of the 4 bytes mod 256. Later input changes do not affect the frame. busy goes high on this transition.
- WAIT_REL_DLY: line released for RESP_DELAY, then ACK_LOW.
- ACK_LOW: drive low for RESP, then ACK_HIGH.
- ACK_HIGH: release for RESP, then BIT_LOW with bit index 0.
- BIT_LOW: drive low for BIT_LOW, then BIT_HIGH.
- BIT_HIGH: release for BIT1_HIGH if the current MSB is 1, otherwise BIT0_HIGH. Then shift left and increment the index. If index was 39, go to END_LOW; otherwise go to BIT_LOW.
- Bits go out MSB-first, hum_int first.
- END_LOW: drive low for BIT_LOW, then release. frame_done=1 for one cycle, busy=0, return to IDLE.
- From acceptance to frame end, dq_in is ignored; the responder owns the timing. A host pulling low during the frame causes no abort.
- dq_drive_low is registered (a state decode registered on the transition edge) and is never X. Only the ACK_LOW, BIT_LOW and END_LOW states drive low.
- Back-to-back starts: a new start is accepted only after returning to IDLE. Low time during the frame does not count toward the next start.

Test Plan:
- Sim overrides: TICKS_PER_US=1, START_MIN_US=100.
- Nominal frame with bytes 0x37,0x00,0x19,0x00, host low 150 cycles then release:
  - line low for 80 cycles after a 30-cycle delay, then high 80;
  - then 40 bits decode as 0x37 0x00 0x19 0x00 0x50;
  - frame_done pulses once; busy is high for the whole span.
- Short start: host low for 99 cycles, then release -> no drive, busy stays 0. A following 100-cycle low is accepted and the frame is sent.
- Bit timing: bytes 0xFF,0x00,0x00,0x00 (checksum 0xFF):
  - high widths are 70 cycles for bits 0-7 and 32-39, and 27 cycles elsewhere;
  - every low preamble is exactly 50 cycles.
- Snapshot: change all inputs to 0xAA mid-frame -> transmitted frame still carries the originally latched bytes and checksum.
- Reset mid-frame: assert rst during bit 12 low -> dq_drive_low=0 on that edge, busy=0, no frame_done. A new start after reset produces a full frame.
- Checksum wrap: bytes 0x80,0x80,0x80,0x81 -> checksum 0x01.

Source files
------------

// File: rtl/dht11_responder.sv
// rtl/dht11_responder.sv - DHT11 sensor emulator: detects host start, sends ack and 40-bit frame
module dht11_responder #(
  parameter int unsigned TICKS_PER_US  = 1,
  parameter int unsigned START_MIN_US  = 18000,
  parameter int unsigned RESP_DELAY_US = 30,
  parameter int unsigned RESP_US       = 80,
  parameter int unsigned BIT_LOW_US    = 50,
  parameter int unsigned BIT0_HIGH_US  = 27,
  parameter int unsigned BIT1_HIGH_US  = 70
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dq_in,
  output logic       dq_drive_low,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned START_CYC = START_MIN_US  * TICKS_PER_US;
  localparam int unsigned DLY_CYC   = RESP_DELAY_US * TICKS_PER_US;
  localparam int unsigned RESP_CYC  = RESP_US       * TICKS_PER_US;
  localparam int unsigned BLOW_CYC  = BIT_LOW_US    * TICKS_PER_US;
  localparam int unsigned B0_CYC    = BIT0_HIGH_US  * TICKS_PER_US;
  localparam int unsigned B1_CYC    = BIT1_HIGH_US  * TICKS_PER_US;

  localparam int unsigned MAX_A   = (START_CYC > DLY_CYC)  ? START_CYC : DLY_CYC;
  localparam int unsigned MAX_B   = (MAX_A > RESP_CYC)     ? MAX_A     : RESP_CYC;
  localparam int unsigned MAX_C   = (MAX_B > BLOW_CYC)     ? MAX_B     : BLOW_CYC;
  localparam int unsigned MAX_D   = (MAX_C > B0_CYC)       ? MAX_C     : B0_CYC;
  localparam int unsigned MAX_CYC = (MAX_D > B1_CYC)       ? MAX_D     : B1_CYC;
  localparam int          CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] START_C = CW'(START_CYC);
  localparam logic [CW-1:0] DLY_C   = CW'(DLY_CYC);
  localparam logic [CW-1:0] RESP_C  = CW'(RESP_CYC);
  localparam logic [CW-1:0] BLOW_C  = CW'(BLOW_CYC);
  localparam logic [CW-1:0] B0_C    = CW'(B0_CYC);
  localparam logic [CW-1:0] B1_C    = CW'(B1_CYC);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE, WAIT_REL_DLY, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, phase_len;
  logic [39:0]   shreg, shreg_nxt;
  logic [5:0]    idx, idx_nxt;
  logic          sync1, sync2;
  logic          drive_nxt, busy_nxt, done_nxt, phase_last;
  logic [7:0]    csum;

  assign csum       = hum_int + hum_dec + temp_int + temp_dec;
  assign phase_last = (cnt == phase_len - CW'(1));

  always_comb begin
    phase_len = BLOW_C;
    case (state)
      WAIT_REL_DLY: phase_len = DLY_C;
      ACK_LOW:      phase_len = RESP_C;
      ACK_HIGH:     phase_len = RESP_C;
      BIT_HIGH:     phase_len = shreg[39] ? B1_C : B0_C;
      default:      phase_len = BLOW_C;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    shreg_nxt = shreg;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // Low time saturates so a very long host low still qualifies as a start.
        if (!sync2) begin
          cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        end else if (cnt >= START_C) begin
          state_nxt = WAIT_REL_DLY;
          cnt_nxt   = '0;
          shreg_nxt = {hum_int, hum_dec, temp_int, temp_dec, csum};
        end else begin
          cnt_nxt = '0;
        end
      end
      WAIT_REL_DLY: if (phase_last) begin state_nxt = ACK_LOW;  cnt_nxt = '0; end
      ACK_LOW:      if (phase_last) begin state_nxt = ACK_HIGH; cnt_nxt = '0; end
      ACK_HIGH: begin
        if (phase_last) begin
          state_nxt = BIT_LOW;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      end
      BIT_LOW:      if (phase_last) begin state_nxt = BIT_HIGH; cnt_nxt = '0; end
      BIT_HIGH: begin
        if (phase_last) begin
          cnt_nxt   = '0;
          shreg_nxt = {shreg[38:0], 1'b0};
          idx_nxt   = idx + 6'd1;
          state_nxt = (idx == 6'd39) ? END_LOW : BIT_LOW;
        end
      end
      END_LOW: begin
        if (phase_last) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    drive_nxt = (state_nxt == ACK_LOW) || (state_nxt == BIT_LOW) || (state_nxt == END_LOW);
    busy_nxt  = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      idx          <= '0;
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      dq_drive_low <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      shreg        <= shreg_nxt;
      idx          <= idx_nxt;
      sync1        <= dq_in;
      sync2        <= sync1;
      dq_drive_low <= drive_nxt;
      busy         <= busy_nxt;
      frame_done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// tb/tb_dht11_responder.sv - directed self-checking bench for dht11_responder
module tb_dht11_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_low = 1'b0;
  logic       dq_in;
  logic       dq_drive_low;
  logic [7:0] hum_int = 8'h00, hum_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;
  logic       busy, frame_done;

  int checks = 0;
  int failures = 0;
  logic busy_ok;

  // Open-drain line with pull-up: low if either end pulls it.
  assign dq_in = ~(host_low | dq_drive_low);

  always #5 clk = ~clk;

  dht11_responder #(
    .TICKS_PER_US(1),
    .START_MIN_US(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dq_in(dq_in),
    .dq_drive_low(dq_drive_low),
    .hum_int(hum_int),
    .hum_dec(hum_dec),
    .temp_int(temp_int),
    .temp_dec(temp_dec),
    .busy(busy),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic host_start(input int n);
    host_low = 1'b1;
    repeat (n) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic wait_busy();
    int t = 0;
    while (busy !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("busy_rise", busy, 1);
  endtask

  task automatic count_run(input logic lvl, output int n);
    n = 0;
    while (dq_drive_low === lvl && n < 500) begin
      n++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input logic [39:0] exp);
    int n;
    logic [39:0] got;
    got = '0;
    wait_busy();
    busy_ok = 1'b1;
    count_run(1'b0, n); chk("wait_dly", n, 30);
    count_run(1'b1, n); chk("ack_low", n, 80);
    count_run(1'b0, n); chk("ack_high", n, 80);
    for (int i = 0; i < 40; i++) begin
      count_run(1'b1, n); chk($sformatf("bit%0d_low", i), n, 50);
      count_run(1'b0, n); chk($sformatf("bit%0d_high", i), n, exp[39-i] ? 70 : 27);
      got = {got[38:0], (n > 48)};
    end
    count_run(1'b1, n); chk("end_low", n, 50);
    chk("frame_data", got, exp);
    chk("frame_done_pulse", frame_done, 1);
    chk("busy_end", busy, 0);
    chk("busy_span", busy_ok, 1);
    @(negedge clk);
    chk("frame_done_clear", frame_done, 0);
  endtask

  initial begin
    int rises;
    int t;
    logic prev;
    logic quiet;

    repeat (3) @(negedge clk);
    chk("rst_drive", dq_drive_low, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Nominal frame
    hum_int = 8'h37; hum_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h00;
    host_start(150);
    run_frame(40'h3700190050);
    repeat (20) @(negedge clk);

    // Short start ignored, exact-threshold start accepted
    host_start(99);
    quiet = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (busy !== 1'b0 || dq_drive_low !== 1'b0) quiet = 1'b0;
    end
    chk("short_start_ignored", quiet, 1);
    host_start(100);
    run_frame(40'h3700190050);
    repeat (20) @(negedge clk);

    // Bit timing with long and short high widths
    hum_int = 8'hFF; hum_dec = 8'h00; temp_int = 8'h00; temp_dec = 8'h00;
    host_start(120);
    run_frame(40'hFF000000FF);
    repeat (20) @(negedge clk);

    // Snapshot: inputs change mid-frame
    hum_int = 8'h12; hum_dec = 8'h34; temp_int = 8'h56; temp_dec = 8'h78;
    host_start(150);
    fork
      run_frame(40'h1234567814);
      begin
        repeat (200) @(negedge clk);
        hum_int = 8'hAA; hum_dec = 8'hAA; temp_int = 8'hAA; temp_dec = 8'hAA;
      end
    join
    repeat (20) @(negedge clk);

    // Reset during bit 12 low preamble
    hum_int = 8'h01; hum_dec = 8'h02; temp_int = 8'h03; temp_dec = 8'h04;
    host_start(150);
    wait_busy();
    rises = 0;
    t = 0;
    prev = dq_drive_low;
    while (rises < 14 && t < 5000) begin
      @(negedge clk);
      t++;
      if (dq_drive_low === 1'b1 && prev === 1'b0) rises++;
      prev = dq_drive_low;
    end
    chk("reach_bit12", rises, 14);
    repeat (10) @(negedge clk);
    chk("bit12_driving", dq_drive_low, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_drive", dq_drive_low, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", frame_done, 0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || dq_drive_low !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("post_rst_quiet", quiet, 1);
    hum_int = 8'h37; hum_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h00;
    host_start(150);
    run_frame(40'h3700190050);
    repeat (20) @(negedge clk);

    // Checksum wrap
    hum_int = 8'h80; hum_dec = 8'h80; temp_int = 8'h80; temp_dec = 8'h81;
    host_start(150);
    run_frame(40'h8080808101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
